// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite channel bundle between a command master and a register slave.
// The master modport drives AW/W/AR payloads, their valids and the B/R readies;
// the slave modport is its mirror image.
interface axi_lite_cmd_master_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]              M_AXI_AWPROT;
    logic                    M_AXI_AWVALID;
    logic                    M_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
    logic                    M_AXI_WVALID;
    logic                    M_AXI_WREADY;
    logic [1:0]              M_AXI_BRESP;
    logic                    M_AXI_BVALID;
    logic                    M_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]              M_AXI_ARPROT;
    logic                    M_AXI_ARVALID;
    logic                    M_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]              M_AXI_RRESP;
    logic                    M_AXI_RVALID;
    logic                    M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns one read/write command word into
// one AXI4-Lite transaction and returns one response word per command.
// Every AXI output comes straight from a register, so no AXI input reaches an
// AXI output combinationally.
module axi_lite_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 8
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESET,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            err_sticky,
    axi_lite_cmd_master_if.master           m_axi
);
    localparam logic [C_M_AXI_DATA_WIDTH-1:0]   DATA_ZERO = '0;
    localparam logic [C_M_AXI_ADDR_WIDTH-1:0]   ADDR_ZERO = '0;
    localparam logic [C_M_AXI_DATA_WIDTH/8-1:0] STRB_ZERO = '0;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RSP          = 3'd5
    } state_t;

    state_t                          state_r;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_r;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_r;
    logic                            awvalid_r;
    logic                            wvalid_r;
    logic                            arvalid_r;
    logic                            bready_r;
    logic                            rready_r;
    logic                            aw_done_r;
    logic                            w_done_r;
    logic                            rsp_valid_r;
    logic                            rsp_write_r;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_r;
    logic [1:0]                      rsp_resp_r;
    logic                            err_sticky_r;

    logic cmd_fire_s;
    logic aw_hs_s;
    logic w_hs_s;
    logic ar_hs_s;
    logic b_hs_s;
    logic r_hs_s;

    // Commands are only taken in IDLE and never while reset is asserted.
    assign cmd_ready  = (state_r == IDLE) && !M_AXI_ARESET;
    assign cmd_fire_s = cmd_valid && cmd_ready;

    assign aw_hs_s = awvalid_r && m_axi.M_AXI_AWREADY;
    assign w_hs_s  = wvalid_r  && m_axi.M_AXI_WREADY;
    assign ar_hs_s = arvalid_r && m_axi.M_AXI_ARREADY;
    assign b_hs_s  = bready_r  && m_axi.M_AXI_BVALID;
    assign r_hs_s  = rready_r  && m_axi.M_AXI_RVALID;

    // Read and write share the latched address; only one valid is ever up.
    assign m_axi.M_AXI_AWADDR  = addr_r;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = awvalid_r;
    assign m_axi.M_AXI_WDATA   = wdata_r;
    assign m_axi.M_AXI_WSTRB   = wstrb_r;
    assign m_axi.M_AXI_WVALID  = wvalid_r;
    assign m_axi.M_AXI_BREADY  = bready_r;
    assign m_axi.M_AXI_ARADDR  = addr_r;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = arvalid_r;
    assign m_axi.M_AXI_RREADY  = rready_r;

    assign rsp_valid  = rsp_valid_r;
    assign rsp_write  = rsp_write_r;
    assign rsp_rdata  = rsp_rdata_r;
    assign rsp_resp   = rsp_resp_r;
    assign err_sticky = err_sticky_r;

    // Transaction sequencer: command latch, AXI channel handshakes, response hold.
    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state_r      <= IDLE;
            addr_r       <= ADDR_ZERO;
            wdata_r      <= DATA_ZERO;
            wstrb_r      <= STRB_ZERO;
            awvalid_r    <= 1'b0;
            wvalid_r     <= 1'b0;
            arvalid_r    <= 1'b0;
            bready_r     <= 1'b0;
            rready_r     <= 1'b0;
            aw_done_r    <= 1'b0;
            w_done_r     <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_write_r  <= 1'b0;
            rsp_rdata_r  <= DATA_ZERO;
            rsp_resp_r   <= 2'b00;
            err_sticky_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_fire_s) begin
                        addr_r      <= cmd_addr;
                        wdata_r     <= cmd_wdata;
                        wstrb_r     <= cmd_wstrb;
                        rsp_write_r <= cmd_write;
                        aw_done_r   <= 1'b0;
                        w_done_r    <= 1'b0;
                        if (cmd_write) begin
                            awvalid_r <= 1'b1;
                            wvalid_r  <= 1'b1;
                            state_r   <= WR_ADDR_DATA;
                        end else begin
                            arvalid_r <= 1'b1;
                            state_r   <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    // AW and W complete independently, in either order.
                    if (aw_hs_s) begin
                        awvalid_r <= 1'b0;
                        aw_done_r <= 1'b1;
                    end
                    if (w_hs_s) begin
                        wvalid_r <= 1'b0;
                        w_done_r <= 1'b1;
                    end
                    if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
                        aw_done_r <= 1'b0;
                        w_done_r  <= 1'b0;
                        bready_r  <= 1'b1;
                        state_r   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (b_hs_s) begin
                        bready_r     <= 1'b0;
                        rsp_resp_r   <= m_axi.M_AXI_BRESP;
                        rsp_rdata_r  <= DATA_ZERO;
                        rsp_valid_r  <= 1'b1;
                        err_sticky_r <= err_sticky_r || (m_axi.M_AXI_BRESP != 2'b00);
                        state_r      <= RSP;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs_s) begin
                        arvalid_r <= 1'b0;
                        rready_r  <= 1'b1;
                        state_r   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (r_hs_s) begin
                        rready_r     <= 1'b0;
                        rsp_resp_r   <= m_axi.M_AXI_RRESP;
                        rsp_rdata_r  <= m_axi.M_AXI_RDATA;
                        rsp_valid_r  <= 1'b1;
                        err_sticky_r <= err_sticky_r || (m_axi.M_AXI_RRESP != 2'b00);
                        state_r      <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: drop every handshake and recover.
                    awvalid_r   <= 1'b0;
                    wvalid_r    <= 1'b0;
                    arvalid_r   <= 1'b0;
                    bready_r    <= 1'b0;
                    rready_r    <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
- AXI4-Lite master that turns a simple single-word command stream (read/write, address, data, strobe) into AXI4-Lite transactions.
- Returns a response word per command.
- Sits directly upstream of the team's AXI4-Lite register slave; it is the block that drives that slave's AW/W/B/AR/R channels from FPGA-side logic.
- One transaction outstanding at a time.

Parameters:
- C_M_AXI_DATA_WIDTH, 32, data width in bits; must be 32 (WSTRB width 4).
- C_M_AXI_ADDR_WIDTH, 8, byte address width.

Ports:
- M_AXI_ACLK  in  1  clock
- M_AXI_ARESET  in  1  synchronous reset, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads)
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes (ignored for reads)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_write  out  1  echoes cmd_write of the completed command
- rsp_rdata  out  DATA_WIDTH  RDATA for reads; 0 for writes
- rsp_resp  out  2  BRESP or RRESP
- err_sticky  out  1  set on any resp != 2'b00; cleared only by reset
- M_AXI_AWADDR  out  ADDR_WIDTH;  M_AXI_AWPROT  out  3 (constant 3'b000);  M_AXI_AWVALID  out  1;  M_AXI_AWREADY  in  1
- M_AXI_WDATA  out  DATA_WIDTH;  M_AXI_WSTRB  out  DATA_WIDTH/8;  M_AXI_WVALID  out  1;  M_AXI_WREADY  in  1
- M_AXI_BRESP  in  2;  M_AXI_BVALID  in  1;  M_AXI_BREADY  out  1
- M_AXI_ARADDR  out  ADDR_WIDTH;  M_AXI_ARPROT  out  3 (constant 3'b000);  M_AXI_ARVALID  out  1;  M_AXI_ARREADY  in  1
- M_AXI_RDATA  in  DATA_WIDTH;  M_AXI_RRESP  in  2;  M_AXI_RVALID  in  1;  M_AXI_RREADY  out  1

Behaviour:
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- Reset (any cycle, including mid-transaction):
  - State returns to IDLE next edge.
  - AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, err_sticky = 0.
  - AW/AR address, WDATA, WSTRB, rsp_rdata, rsp_resp, rsp_write = 0.
  - No in-flight transaction is completed or reported.
- cmd_ready = (state == IDLE) && !M_AXI_ARESET; combinational from state.
- IDLE:
  - On command handshake, latch addr/wdata/wstrb/write into registers.
  - Write → WR_ADDR_DATA, with AWVALID = WVALID = 1 from the next cycle.
  - Read → RD_ADDR, with ARVALID = 1 from the next cycle.
- WR_ADDR_DATA:
  - AW and W are independent.
  - AWVALID drops the cycle after its AWREADY handshake; WVALID drops the cycle after its WREADY handshake.
  - Either order or simultaneous handshakes are legal.
  - AWADDR/WDATA/WSTRB are held stable while the corresponding valid is high.
  - When both have handshaken (tracked by two done flags), go to WR_RESP with BREADY = 1.
- WR_RESP: on BVALID && BREADY, capture BRESP, rdata = 0, BREADY → 0, go to RSP.
- RD_ADDR: ARVALID held with a stable address until ARREADY; then ARVALID → 0, RREADY → 1, go to RD_DATA.
- RD_DATA: on RVALID && RREADY, capture RDATA/RRESP, RREADY → 0, go to RSP.
- RSP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On the rsp handshake, rsp_valid → 0 and state → IDLE; cmd_ready is high the following cycle.
- Latency with an always-ready slave whose B/R responses are registered (1 cycle):
  - Command accepted at cycle 0; AW/W or AR valid at cycle 1.
  - BVALID/RVALID at cycle 2; rsp_valid at cycle 3.
  - Next command accepted no earlier than the cycle after the rsp handshake.
- err_sticky is set in the same edge that captures a non-zero resp.
- Never more than one outstanding AXI transaction.
- No combinational path from any AXI input to any AXI output.
- A valid signal is never deasserted without its ready having been seen.
- Address is passed unmodified; low bits are not masked.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, strb 0xF to an always-ready slave → AWVALID/WVALID high cycle 1, rsp_valid cycle 3 with rsp_write = 1, rsp_resp = 0, rsp_rdata = 0; slave reg[4] = 0xDEADBEEF.
- Read back addr 0x10 → ARVALID at cycle 1, rsp_rdata = 0xDEADBEEF, rsp_resp = 0; write with strb 0x3, data 0x00001234, then read → 0xDEAD1234.
- Slave holds WREADY low 5 cycles while AWREADY = 1 → AWVALID drops after 1 cycle, WVALID and WDATA stable until WREADY, BREADY rises only after W handshake; reverse case (AWREADY late) also passes.
- rsp_ready held low 10 cycles → rsp_valid and fields stable, cmd_ready = 0, no new AXI valid asserted despite cmd_valid = 1.
- Slave returns RRESP = 2'b10 → rsp_resp = 2, err_sticky = 1 and stays 1 through subsequent OKAY transactions until reset.
- Assert M_AXI_ARESET while in WR_ADDR_DATA → next cycle all valids/readies and rsp_valid = 0, cmd_ready = 1 after reset release, a fresh read completes normally.
